// File: rtl/rom_load_router_pkg.sv
// Shared types and region-offset helper for the ROM download router.
package rom_load_pkg;

    localparam int ROM_REGIONS = 4;

    typedef logic [1:0] region_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    // Base of region idx is the sum of all region lengths before it; idx 4 yields the image size.
    function automatic logic [31:0] region_base(
        input int          idx,
        input logic [31:0] cpu_size,
        input logic [31:0] snd_size,
        input logic [31:0] til_size,
        input logic [31:0] spr_size
    );
        logic [31:0] base;
        base = '0;
        if (idx > 0) base = base + cpu_size;
        if (idx > 1) base = base + snd_size;
        if (idx > 2) base = base + til_size;
        if (idx > 3) base = base + spr_size;
        return base;
    endfunction

endpackage

// File: rtl/rom_load_router_region_decode.sv
// Combinational image-address decode into {valid, region, offset within region}.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter logic [31:0] CPU_SIZE = 32'h0C000,
    parameter logic [31:0] SND_SIZE = 32'h04000,
    parameter logic [31:0] TIL_SIZE = 32'h18000,
    parameter logic [31:0] SPR_SIZE = 32'h08000
) (
    input  logic [24:0] i_addr,
    output logic        o_valid,
    output region_t     o_region,
    output logic [16:0] o_offset
);

    localparam logic [31:0] BASE1 = region_base(1, CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE);
    localparam logic [31:0] BASE2 = region_base(2, CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE);
    localparam logic [31:0] BASE3 = region_base(3, CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE);
    localparam logic [31:0] TOTAL = region_base(4, CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE);

    // The offset is truncated to 17 bits, so only the low base bits take part in the subtraction.
    localparam logic [16:0] OFF1 = BASE1[16:0];
    localparam logic [16:0] OFF2 = BASE2[16:0];
    localparam logic [16:0] OFF3 = BASE3[16:0];

    logic [31:0] w_addr;

    assign w_addr = {7'd0, i_addr};

    always_comb begin
        o_valid  = 1'b1;
        o_region = 2'd0;
        o_offset = i_addr[16:0];
        if (w_addr < BASE1) begin
            o_region = 2'd0;
        end else if (w_addr < BASE2) begin
            o_region = 2'd1;
            o_offset = i_addr[16:0] - OFF1;
        end else if (w_addr < BASE3) begin
            o_region = 2'd2;
            o_offset = i_addr[16:0] - OFF2;
        end else if (w_addr < TOTAL) begin
            o_region = 2'd3;
            o_offset = i_addr[16:0] - OFF3;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/rom_load_router.sv
// Routes HPS ioctl download bytes into four ROM regions and holds the core in reset while loading.
// Optional running byte checksum output is enabled with `define ROM_LOAD_CKSUM_EN.
module rom_load_router
    import rom_load_pkg::*;
#(
    parameter logic [31:0] CPU_SIZE = 32'h0C000,
    parameter logic [31:0] SND_SIZE = 32'h04000,
    parameter logic [31:0] TIL_SIZE = 32'h18000,
    parameter logic [31:0] SPR_SIZE = 32'h08000,
    parameter int          RST_HOLD = 16
`ifdef ROM_LOAD_CKSUM_EN
    ,
    parameter logic [15:0] EXP_CKSUM = 16'h0000
`endif
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [16:0]            rom_addr,
    output logic [7:0]             rom_data,
    output logic [ROM_REGIONS-1:0] rom_we,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   size_err,
    output logic [24:0]            byte_cnt
`ifdef ROM_LOAD_CKSUM_EN
    ,
    output logic [15:0]            cksum
`endif
);

    localparam logic [31:0] TOTAL32   = region_base(4, CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE);
    localparam logic [24:0] TOTAL_CNT = TOTAL32[24:0];
    localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);
    localparam logic [ROM_REGIONS-1:0] WE_ONE = {{(ROM_REGIONS-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic                   r_dl_prev;
    logic [15:0]            r_hold_cnt;
    logic                   r_oor;
    logic [ROM_REGIONS-1:0] r_rom_we;
    logic [16:0]            r_rom_addr;
    logic [7:0]             r_rom_data;
    logic                   r_core_reset;
    logic                   r_load_done;
    logic                   r_size_err;
    logic [24:0]            r_byte_cnt;

    logic                   w_valid;
    region_t                w_region;
    logic [16:0]            w_offset;
    logic                   w_rise;
    logic                   w_size_bad;

    rom_region_decode #(
        .CPU_SIZE (CPU_SIZE),
        .SND_SIZE (SND_SIZE),
        .TIL_SIZE (TIL_SIZE),
        .SPR_SIZE (SPR_SIZE)
    ) u_decode (
        .i_addr   (ioctl_addr),
        .o_valid  (w_valid),
        .o_region (w_region),
        .o_offset (w_offset)
    );

    assign w_rise = ioctl_download & ~r_dl_prev;

`ifdef ROM_LOAD_CKSUM_EN
    logic [15:0] r_cksum;

    // A zero expected checksum means "don't care", so only the count and range decide.
    assign w_size_bad = (r_byte_cnt != TOTAL_CNT) | r_oor |
                        ((EXP_CKSUM != 16'h0000) && (r_cksum != EXP_CKSUM));
    assign cksum      = r_cksum;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cksum <= '0;
        end else if ((r_state != LOAD) && w_rise) begin
            r_cksum <= '0;
        end else if ((r_state == LOAD) && ioctl_wr && w_valid) begin
            r_cksum <= r_cksum + {8'd0, ioctl_dout};
        end
    end
`else
    assign w_size_bad = (r_byte_cnt != TOTAL_CNT) | r_oor;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_dl_prev    <= 1'b0;
            r_hold_cnt   <= '0;
            r_oor        <= 1'b0;
            r_rom_we     <= '0;
            r_rom_addr   <= '0;
            r_rom_data   <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_size_err   <= 1'b0;
            r_byte_cnt   <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_rom_we  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state      <= LOAD;
                        r_byte_cnt   <= '0;
                        r_size_err   <= 1'b0;
                        r_oor        <= 1'b0;
                        r_core_reset <= 1'b1;
                    end else begin
                        r_core_reset <= ~r_load_done;
                    end
                end
                LOAD: begin
                    r_core_reset <= 1'b1;
                    // The byte arriving alongside the falling download edge is still taken.
                    if (ioctl_wr) begin
                        if (w_valid) begin
                            r_rom_we   <= WE_ONE << w_region;
                            r_rom_addr <= w_offset;
                            r_rom_data <= ioctl_dout;
                            if (r_byte_cnt != 25'h1FFFFFF) begin
                                r_byte_cnt <= r_byte_cnt + 25'd1;
                            end
                        end else begin
                            r_oor <= 1'b1;
                        end
                    end
                    if (!ioctl_download) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= HOLD_INIT;
                    end
                end
                HOLD: begin
                    r_core_reset <= 1'b1;
                    if (w_rise) begin
                        r_state    <= LOAD;
                        r_byte_cnt <= '0;
                        r_size_err <= 1'b0;
                        r_oor      <= 1'b0;
                    end else if (r_hold_cnt == 16'd0) begin
                        r_state      <= IDLE;
                        r_load_done  <= 1'b1;
                        r_size_err   <= w_size_bad;
                        r_core_reset <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign size_err   = r_size_err;
    assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_rom_load_router.sv
// Scoreboard bench for rom_load_router using a scaled-down image (regions 0xC00/0x400/0x1800/0x800).
module tb_rom_load_router;

    localparam logic [24:0] IMG_TOTAL = 25'h03000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_we;
    logic        core_reset;
    logic        load_done;
    logic        size_err;
    logic [24:0] byte_cnt;
`ifdef ROM_LOAD_CKSUM_EN
    logic [15:0] cksum;
`endif

    typedef struct {
        logic [3:0]  we;
        logic [16:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rom_load_router #(
        .CPU_SIZE (32'h00C00),
        .SND_SIZE (32'h00400),
        .TIL_SIZE (32'h01800),
        .SPR_SIZE (32'h00800),
        .RST_HOLD (16)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .size_err       (size_err),
        .byte_cnt       (byte_cnt)
`ifdef ROM_LOAD_CKSUM_EN
        ,
        .cksum          (cksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (reset_n && (rom_we != 4'b0000)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL strobe_unexpected actual we=%b addr=%0h required=no strobe", rom_we, rom_addr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe_we", {28'd0, rom_we}, {28'd0, e.we});
                    checkOutput("strobe_addr", {15'd0, rom_addr}, {15'd0, e.addr});
                    checkOutput("strobe_data", {24'd0, rom_data}, {24'd0, e.data});
                    checkOutput("strobe_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    // One byte write with data = addr[7:0]; in-range bytes queue their expected strobe.
    task automatic applyStimulus(input logic [24:0] addr, input bit last);
        exp_t e;
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = addr[7:0];
        if (last) ioctl_download = 1'b0;
        e.data = addr[7:0];
        e.cyc  = cyc + 1;
        if (addr < 25'h00C00) begin
            e.we = 4'b0001; e.addr = 17'(addr);
        end else if (addr < 25'h01000) begin
            e.we = 4'b0010; e.addr = 17'(addr - 25'h00C00);
        end else if (addr < 25'h02800) begin
            e.we = 4'b0100; e.addr = 17'(addr - 25'h01000);
        end else begin
            e.we = 4'b1000; e.addr = 17'(addr - 25'h02800);
        end
        if (addr < IMG_TOTAL) expQ.push_back(e);
    endtask

    task automatic runDownload(input int count, input bit injectOor, input string tag);
        int  n;
        bit  done;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        for (int i = 0; i < count; i++) begin
            if (injectOor && (i == 'h1000)) applyStimulus(IMG_TOTAL, 1'b0);
            applyStimulus(25'(i), i == count - 1);
        end
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            if (core_reset) n++;
            else done = 1'b1;
        end
        checkOutput({tag, "_hold_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        fork
            runMonitor();
        join_none

        repeat (3) @(negedge clk_sys);
        checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_rom_we", {28'd0, rom_we}, 32'd0);
        checkOutput("rst_byte_cnt", {7'd0, byte_cnt}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        checkOutput("idle_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("idle_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("idle_size_err", {31'd0, size_err}, 32'd0);

        runDownload('h3000, 1'b0, "full");
        checkOutput("full_load_done", {31'd0, load_done}, 32'd1);
        checkOutput("full_size_err", {31'd0, size_err}, 32'd0);
        checkOutput("full_byte_cnt", {7'd0, byte_cnt}, 32'h3000);

        runDownload('h100, 1'b0, "short");
        checkOutput("short_byte_cnt", {7'd0, byte_cnt}, 32'h100);
        checkOutput("short_size_err", {31'd0, size_err}, 32'd1);
        checkOutput("short_load_done", {31'd0, load_done}, 32'd1);
        checkOutput("short_core_reset", {31'd0, core_reset}, 32'd0);

        runDownload('h3000, 1'b1, "oor");
        checkOutput("oor_byte_cnt", {7'd0, byte_cnt}, 32'h3000);
        checkOutput("oor_size_err", {31'd0, size_err}, 32'd1);

        @(negedge clk_sys);
        ioctl_download = 1'b1;
        for (int i = 0; i < 'h500; i++) applyStimulus(25'(i), 1'b0);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        checkOutput("midload_byte_cnt", {7'd0, byte_cnt}, 32'h500);
        @(negedge clk_sys);
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        checkOutput("abort_rom_we", {28'd0, rom_we}, 32'd0);
        checkOutput("abort_rom_addr", {15'd0, rom_addr}, 32'd0);
        checkOutput("abort_rom_data", {24'd0, rom_data}, 32'd0);
        checkOutput("abort_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("abort_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("abort_size_err", {31'd0, size_err}, 32'd0);
        checkOutput("abort_byte_cnt", {7'd0, byte_cnt}, 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        checkOutput("after_abort_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("after_abort_load_done", {31'd0, load_done}, 32'd0);

        runDownload('h3000, 1'b0, "fresh");
        checkOutput("fresh_load_done", {31'd0, load_done}, 32'd1);
        checkOutput("fresh_size_err", {31'd0, size_err}, 32'd0);
        checkOutput("fresh_byte_cnt", {7'd0, byte_cnt}, 32'h3000);

        repeat (3) @(negedge clk_sys);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
